// File: rtl/train_ui_if.sv
// Handshake and status bundle between the training UI controller and its
// surroundings: button, spike strobe, classifier handshake and LED/status outputs.
interface train_ui_if #(
  parameter int NUM_LEDS = 5
);
  logic                button_raw;
  logic                spike_valid;
  logic                proc_done;
  logic                wake_detected;
  logic                command_done;
  logic [NUM_LEDS-1:0] led;
  logic                clear_buffers;
  logic                word_ready;
  logic [15:0]         word_spikes;
  logic                start_processing;
  logic [7:0]          train_count;
  logic                system_ready;
  logic                cmd_timeout;

  modport master (
    output button_raw, spike_valid, proc_done,
    output wake_detected, command_done,
    input  led, clear_buffers, word_ready, word_spikes,
    input  start_processing, train_count, system_ready, cmd_timeout
  );

  modport slave (
    input  button_raw, spike_valid, proc_done,
    input  wake_detected, command_done,
    output led, clear_buffers, word_ready, word_spikes,
    output start_processing, train_count, system_ready, cmd_timeout
  );
endinterface

// File: rtl/train_ui_ctrl.sv
// Training/status UI controller: debounced button, example recording, LED bar.
// Optional command timeout enabled by defining TRAIN_CMD_TIMEOUT_EN.
module train_ui_ctrl #(
  parameter int NUM_LEDS          = 5,
  parameter int NUM_EXAMPLES      = 15,
  parameter int TICK_DIV          = 256,
  parameter int DEBOUNCE_TICKS    = 4,
  parameter int MIN_SPIKES        = 8,
  parameter int ACK_TICKS         = 16,
  parameter int CMD_TIMEOUT_TICKS = 255
) (
  input logic       clk,
  input logic       rst_n,
  train_ui_if.slave bus
);

  localparam int DW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REC, S_CHECK,
    S_PROC, S_READY, S_CMD
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DW-1:0]       r_div;
  logic                w_tick;
  logic [3:0]          r_tcnt;
  logic [1:0]          r_sync;
  logic                w_sync;
  logic [7:0]          r_db;
  logic                r_btn;
  logic                r_btn_d;
  logic                w_press;
  logic                w_release;
  logic [15:0]         r_spikes;
  logic [7:0]          r_count;
  logic [7:0]          w_cnt_inc;
  logic                w_enough;
  logic [7:0]          r_ack;
  logic                r_ack_acc;
  logic                r_start;
  logic [1:0]          r_cdiv;
  logic [3:0]          r_pos;
  logic [15:0]         w_bar;
  logic [NUM_LEDS-1:0] w_led;
  logic [NUM_LEDS-1:0] r_led;
  logic                w_clear;
  logic                w_accept;
  logic                w_timeout;
  logic                w_to_hit;

  assign w_tick    = (r_div == DW'(TICK_DIV - 1));
  assign w_sync    = r_sync[1];
  assign w_press   = r_btn & ~r_btn_d;
  assign w_release = ~r_btn & r_btn_d;
  assign w_cnt_inc = r_count + 8'd1;
  assign w_enough  = (r_spikes >= 16'(MIN_SPIKES));
  assign w_bar     = (16'(r_count) * 16'(NUM_LEDS))
                   / 16'(NUM_EXAMPLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_tcnt  <= '0;
      r_sync  <= '0;
      r_db    <= '0;
      r_btn   <= 1'b0;
      r_btn_d <= 1'b0;
    end else begin
      r_div   <= r_div + 1'b1;
      r_sync  <= {r_sync[0], bus.button_raw};
      r_btn_d <= r_btn;
      if (w_tick)
        r_tcnt <= r_tcnt + 4'd1;
      // any cycle of agreement restarts the stability count
      if (w_sync == r_btn) begin
        r_db <= '0;
      end else if (w_tick) begin
        if (r_db == 8'(DEBOUNCE_TICKS - 1)) begin
          r_btn <= w_sync;
          r_db  <= '0;
        end else begin
          r_db <= r_db + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (w_press) w_next = S_WAIT;
      S_WAIT:
        if (w_press) begin
          w_next  = S_REC;
          w_clear = 1'b1;
        end
      S_REC:
        if (w_release) w_next = S_CHECK;
      S_CHECK: begin
        w_next = S_WAIT;
        if (w_enough) begin
          w_accept = 1'b1;
          if (w_cnt_inc == 8'(NUM_EXAMPLES))
            w_next = S_PROC;
        end
      end
      S_PROC:
        if (bus.proc_done) w_next = S_READY;
      S_READY:
        if (bus.wake_detected) w_next = S_CMD;
      S_CMD:
        if (bus.command_done) begin
          w_next = S_READY;
        end else if (w_to_hit) begin
          w_next    = S_READY;
          w_timeout = 1'b1;
        end
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_spikes  <= '0;
      r_count   <= '0;
      r_ack     <= '0;
      r_ack_acc <= 1'b0;
      r_start   <= 1'b0;
      r_cdiv    <= '0;
      r_pos     <= '0;
      r_led     <= '0;
    end else begin
      r_state <= w_next;
      r_led   <= w_led;
      r_start <= (w_next == S_PROC) && (r_state != S_PROC);
      if (w_clear)
        r_spikes <= '0;
      else if (r_state == S_REC && bus.spike_valid
               && r_spikes != 16'hFFFF)
        r_spikes <= r_spikes + 16'd1;
      if (w_accept)
        r_count <= w_cnt_inc;
      if (w_clear) begin
        r_ack <= '0;
      end else if (r_state == S_CHECK) begin
        r_ack     <= 8'(ACK_TICKS);
        r_ack_acc <= w_enough;
      end else if (w_tick && r_ack != 8'd0) begin
        r_ack <= r_ack - 8'd1;
      end
      // chaser restarts from LED0 on every entry to READY
      if (r_state != S_READY) begin
        r_cdiv <= '0;
        r_pos  <= '0;
      end else if (w_tick) begin
        r_cdiv <= r_cdiv + 2'd1;
        if (r_cdiv == 2'd3)
          r_pos <= (r_pos == 4'(NUM_LEDS - 1))
                 ? 4'd0 : r_pos + 4'd1;
      end
    end
  end

  always_comb begin
    w_led = '0;
    unique case (r_state)
      S_PROC, S_CMD:
        w_led = {NUM_LEDS{r_tcnt[1]}};
      S_REC:
        w_led[0] = r_tcnt[3];
      S_WAIT:
        if (r_ack != 8'd0) begin
          if (r_ack_acc)
            w_led = '1;
          else
            w_led[NUM_LEDS-1] = r_tcnt[0];
        end else begin
          for (int i = 0; i < NUM_LEDS; i++)
            w_led[i] = (16'(i) < w_bar);
        end
      S_READY:
        for (int i = 0; i < NUM_LEDS; i++)
          w_led[i] = (r_pos == 4'(i));
      default:
        w_led = '0;
    endcase
  end

`ifdef TRAIN_CMD_TIMEOUT_EN
  logic [7:0] r_to;

  assign w_to_hit = (r_state == S_CMD)
                 && (r_to == 8'(CMD_TIMEOUT_TICKS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_to <= '0;
    else if (r_state != S_CMD)
      r_to <= '0;
    else if (w_tick && !w_to_hit)
      r_to <= r_to + 8'd1;
  end
`else
  assign w_to_hit = 1'b0;
`endif

  assign bus.led              = r_led;
  assign bus.clear_buffers    = w_clear;
  assign bus.word_ready       = w_accept;
  assign bus.word_spikes      = r_spikes;
  assign bus.start_processing = r_start;
  assign bus.train_count      = r_count;
  assign bus.system_ready     = (r_state == S_READY)
                             || (r_state == S_CMD);
  assign bus.cmd_timeout      = w_timeout;

endmodule
